// File: rtl/load_store_unit.sv
// load_store_unit: bridges decode and a synchronous data memory; posts stores,
// stalls on loads and returns each load as a one-cycle register-file write.
module load_store_unit #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int RW = 4,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_ld,
    input  logic          req_st,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] st_data,
    input  logic [RW-1:0] dst_in,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall,
    output logic          load_en,
    output logic [RW-1:0] load_dst,
    output logic [DW-1:0] load_data,
    output logic          err
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    state_t        state_q;
    logic [3:0]    cnt_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q, load_data_q;
    logic [RW-1:0] load_dst_q;
    logic          mem_we_q, mem_re_q, load_en_q, err_q;
    logic          open, ld_ok, st_ok, both;
    // requests are only sampled outside WAIT; RESP accepts with no bubble
    assign open  = state_q != S_WAIT;
    assign ld_ok = open & req_ld & ~req_st;
    assign st_ok = open & req_st & ~req_ld;
    assign both  = open & req_ld & req_st;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            load_en_q   <= 1'b0;
            load_dst_q  <= '0;
            load_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            mem_we_q  <= st_ok;
            mem_re_q  <= ld_ok;
            err_q     <= both;
            load_en_q <= 1'b0;
            if (state_q == S_WAIT) begin
                if (cnt_q == 4'd1) begin
                    load_data_q <= mem_rdata;
                    load_en_q   <= 1'b1;
                    state_q     <= S_RESP;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
            end else begin
                state_q <= ld_ok ? S_WAIT : S_IDLE;
                if (st_ok || ld_ok) mem_addr_q <= addr;
                if (st_ok) mem_wdata_q <= st_data;
                if (ld_ok) begin
                    load_dst_q <= dst_in;
                    cnt_q      <= 4'(RD_LAT);
                end
            end
        end
    end
    assign stall     = state_q == S_WAIT;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign load_en   = load_en_q;
    assign load_dst  = load_dst_q;
    assign load_data = load_data_q;
    assign err       = err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed requests push expected strobes into a scoreboard;
// a negedge monitor pops and compares every strobe the unit emits.
module tb_load_store_unit;
    localparam int AW = 8, DW = 8, RW = 4, RD_LAT = 2;
    localparam logic [1:0] K_WE = 2'd0, K_RE = 2'd1, K_LE = 2'd2, K_ERR = 2'd3;

    typedef struct packed {
        logic [15:0] cyc;
        logic [1:0]  kind;
        logic [7:0]  a;
        logic [7:0]  d;
        logic [3:0]  dst;
    } ev_t;

    logic clk = 1'b0, rst_n = 1'b1;
    logic req_ld = 1'b0, req_st = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] st_data = '0;
    logic [RW-1:0] dst_in = '0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata, load_data;
    logic mem_we, mem_re, stall, load_en, err;
    logic [RW-1:0] load_dst;

    load_store_unit #(.AW(AW), .DW(DW), .RW(RW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req_ld(req_ld), .req_st(req_st), .addr(addr),
        .st_data(st_data), .dst_in(dst_in), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .stall(stall),
        .load_en(load_en), .load_dst(load_dst), .load_data(load_data), .err(err)
    );

    always #5 clk = ~clk;

    // synchronous memory: writes land on the edge, reads register mem_addr each edge
    logic [7:0] mem [256];
    logic mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
            mem[8'h10] <= 8'h7E;
            mem_ready <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t sb[$];
    bit stall_exp[1024];
    bit mon_en = 1'b0;
    int n_cmp = 0, n_bad = 0;

    always @(negedge clk) begin
        ev_t act, e;
        if (mon_en && rst_n) begin
            n_cmp++;
            if (stall !== stall_exp[cyc]) begin
                n_bad++;
                $display("FAIL stall @%0d: got %0b want %0b", cyc, stall, stall_exp[cyc]);
            end
            if (mem_we || mem_re || load_en || err) begin
                act = '0;
                act.cyc = 16'(cyc);
                if (mem_we) begin
                    act.kind = K_WE; act.a = mem_addr; act.d = mem_wdata;
                end else if (mem_re) begin
                    act.kind = K_RE; act.a = mem_addr;
                end else if (load_en) begin
                    act.kind = K_LE; act.d = load_data; act.dst = load_dst;
                end else begin
                    act.kind = K_ERR;
                end
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected @%0d: got kind=%0d a=%h d=%h dst=%h want none",
                             cyc, act.kind, act.a, act.d, act.dst);
                end else begin
                    e = sb.pop_front();
                    if (act != e) begin
                        n_bad++;
                        $display("FAIL event @%0d: got cyc=%0d kind=%0d a=%h d=%h dst=%h want cyc=%0d kind=%0d a=%h d=%h dst=%h",
                                 cyc, act.cyc, act.kind, act.a, act.d, act.dst,
                                 e.cyc, e.kind, e.a, e.d, e.dst);
                    end
                end
            end
        end
    end

    task automatic push(input int c, input logic [1:0] k, input logic [7:0] a,
                        input logic [7:0] d, input logic [3:0] dst);
        ev_t e;
        e.cyc = 16'(c); e.kind = k; e.a = a; e.d = d; e.dst = dst;
        sb.push_back(e);
    endtask

    // offers a request and holds it while stall is high, then records expectations
    task automatic send(input logic ld, input logic st, input logic [7:0] a,
                        input logic [7:0] d, input logic [3:0] dst, input logic [7:0] expd);
        int w = 0;
        @(negedge clk);
        req_ld = ld; req_st = st; addr = a; st_data = d; dst_in = dst;
        while (stall && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (stall) begin
            n_cmp++; n_bad++;
            $display("FAIL hold-timeout: got stall=1 after %0d cycles want 0", w);
        end
        if (st && !ld) push(cyc + 1, K_WE, a, d, 4'h0);
        if (ld && !st) begin
            push(cyc + 1, K_RE, a, 8'h00, 4'h0);
            push(cyc + RD_LAT + 1, K_LE, 8'h00, expd, dst);
            for (int i = 1; i <= RD_LAT; i++) stall_exp[cyc + i] = 1'b1;
        end
        if (ld && st) push(cyc + 1, K_ERR, 8'h00, 8'h00, 4'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_ld = 1'b0; req_st = 1'b0;
        end
    endtask

    task automatic chk_zero(input string tag);
        logic [47:0] v;
        v = {mem_addr, mem_wdata, mem_we, mem_re, stall, load_en, load_dst, load_data, err, 3'b000};
        n_cmp++;
        if (v != '0) begin
            n_bad++;
            $display("FAIL %s: got outputs %h want 0", tag, v);
        end
    endtask

    initial begin
        #3 rst_n = 1'b0;
        #1 chk_zero("reset");
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        mon_en = 1'b1;
        idle(10);
        // back-to-back posted stores
        send(1'b0, 1'b1, 8'h3C, 8'hA5, 4'h0, 8'h00);
        send(1'b0, 1'b1, 8'h3D, 8'h5A, 4'h0, 8'h00);
        idle(2);
        // single load from preloaded memory
        send(1'b1, 1'b0, 8'h10, 8'h00, 4'h5, 8'h7E);
        idle(5);
        // store then load to the same address, then requests offered during WAIT
        send(1'b0, 1'b1, 8'h10, 8'h99, 4'h0, 8'h00);
        send(1'b1, 1'b0, 8'h10, 8'h00, 4'h3, 8'h99);
        send(1'b0, 1'b1, 8'h20, 8'h11, 4'h0, 8'h00);
        send(1'b1, 1'b0, 8'h3C, 8'h00, 4'hA, 8'hA5);
        send(1'b1, 1'b0, 8'h3D, 8'h00, 4'h1, 8'h5A);
        idle(5);
        // conflicting request
        send(1'b1, 1'b1, 8'h44, 8'h33, 4'h2, 8'h00);
        idle(4);
        // reset during the first WAIT cycle abandons the load
        send(1'b1, 1'b0, 8'h20, 8'h00, 4'h7, 8'h11);
        @(negedge clk);
        req_ld = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_zero("reset-mid-load");
        sb.delete();
        for (int i = cyc; i < 1024; i++) stall_exp[i] = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        idle(6);
        send(1'b1, 1'b0, 8'h20, 8'h00, 4'h7, 8'h11);
        idle(8);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the register file and the synchronous data memory.
- Accepts load/store requests from decode, drives the memory port, and returns load results as a one-cycle load-enable pulse with destination register code and data.
- Stalls the program counter while a load is outstanding.
- Stores are posted with no stall.

Parameters:
AW, 8, data memory address width
DW, 8, data width
RW, 4, register code width (matches the register enum encoding)
RD_LAT, 2, memory read latency in cycles (legal range 1..15)

Ports:
clk  in  1  system clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
req_ld  in  1  load request, sampled on posedge when stall=0
req_st  in  1  store request, sampled on posedge when stall=0
addr  in  AW  memory address for the request
st_data  in  DW  store data (register file storData)
dst_in  in  RW  destination register code for a load
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_we  out  1  memory write strobe, one cycle per store
mem_re  out  1  memory read strobe, one cycle per load
mem_rdata  in  DW  memory read data
stall  out  1  high while a load is outstanding; upstream holds its instruction
load_en  out  1  one-cycle pulse; register file writes load_data to load_dst
load_dst  out  RW  destination register code
load_data  out  DW  loaded data
err  out  1  one-cycle pulse: req_ld and req_st sampled high together

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cnt=0, all outputs 0 (mem_addr, mem_wdata, load_dst, load_data zeroed). Reset during WAIT/RESP abandons the load: no load_en is ever issued for it.
- FSM states: IDLE, WAIT, RESP. stall = (state==WAIT). Requests are sampled only in IDLE and RESP; in WAIT they are ignored and upstream must hold them.
- Store accept (edge E0, req_st=1, req_ld=0):
  - Cycle 1: mem_we=1, mem_addr=addr, mem_wdata=st_data.
  - State stays IDLE, so back-to-back stores run one per cycle.
  - mem_we drops in the next cycle unless a new store is accepted.
- Load accept (edge E0, req_ld=1, req_st=0):
  - Register addr→mem_addr, dst_in→load_dst, cnt=RD_LAT. Go to WAIT.
  - mem_re=1 in cycle 1 only.
  - mem_addr holds until the load completes.
- In WAIT, each edge:
  - If cnt==1: capture mem_rdata into load_data and go to RESP.
  - Otherwise: cnt decrements.
- RESP:
  - load_en=1 for exactly one cycle, and load_dst/load_data are valid.
  - Next state is IDLE, or WAIT/IDLE directly if a new request is accepted at the edge ending RESP (no bubble).
- Load timeline: stall high in cycles 1..RD_LAT, load_en high in cycle RD_LAT+1.
- Store in cycle N followed by load of the same address accepted at E(N): the write reaches memory before mem_re, so the load returns the new value.
- req_ld and req_st high together:
  - Neither is performed.
  - err=1 for the next cycle.
  - State unchanged.
- load_data and load_dst hold their last values after load_en falls.
- mem_wdata holds its last value when mem_we=0.

Test Plan:
- Reset then idle: rst_n low mid-cycle → all outputs 0 immediately; no strobes for 10 cycles with no requests.
- Single store: addr=0x3C, st_data=0xA5 → next cycle mem_we=1, mem_addr=0x3C, mem_wdata=0xA5; stall stays 0; a second store (0x3D, 0x5A) on the next edge produces mem_we on two consecutive cycles.
- Load, RD_LAT=2: addr=0x10, dst_in=regx, memory returns 0x7E → mem_re in cycle 1 only; stall high in cycles 1–2; load_en in cycle 3 with load_dst=regx, load_data=0x7E.
- Store then load to the same address: store 0x10←0x99 followed by load 0x10 → load_data=0x99. A request offered during WAIT is held by the bench and accepted only at the RESP edge, with no lost or duplicated strobes.
- Conflict: req_ld=req_st=1 → err pulse for 1 cycle; no mem_we/mem_re; stall=0.
- Reset mid-load: assert rst_n=0 in cycle 1 of a WAIT → stall and mem_re clear immediately; no load_en after release; a fresh load then completes normally.
